hazard_stall_unit: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage MIPS core; sits in ID, directly upstream of the control decoder, and drives its Stall_i.
- Detects load-use hazards and branch/jump redirects, and handles multi-cycle data-memory accesses.
- Produces the stall, flush and pipeline-register write enables, plus a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/hazard_stall_unit_pkg.sv | 33 +++
 rtl/hazard_stall_unit_stall_counter.sv | 20 ++
 rtl/hazard_stall_unit.sv | 104 ++++++++++
 tb/tb_hazard_stall_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared opcode, data-memory access and FSM encodings for the ID-stage hazard logic.
// Also holds the per-opcode source-register usage helpers.
package hazard_stall_unit_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BRANCH = 6'b000100;
    localparam logic [5:0] OP_JUMP   = 6'b000010;

    typedef enum logic [1:0] {
        NOAC = 2'd0,
        BYTE = 2'd1,
        HALF = 2'd2,
        WORD = 2'd3
    } dmem_ac_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1
    } state_e;

    function automatic logic uses_rs(input logic [5:0] op);
        return (op != OP_JUMP);
    endfunction

    // rt is a destination for I-type ALU ops and loads, so only these read it.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BRANCH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_stall_counter.sv
// Saturating up-counter with synchronous active-low clear.
// One-cycle update latency; holds at all-ones instead of wrapping.
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall controller: load-use stall, redirect flush, data-memory freeze.
// Control outputs are combinational (same cycle); counter and timeout update on the next edge.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       IF_ID_Op_i,
    input  logic [4:0]       IF_ID_Rs_i,
    input  logic [4:0]       IF_ID_Rt_i,
    input  logic [1:0]       ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_Rt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             Dmem_busy_i,
    output logic             Stall_o,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_Flush_o,
    output logic             Pipe_Freeze_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic             Timeout_o
);

    localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              load_use;

    // Register 0 is excluded by requiring a nonzero load destination.
    assign load_use = (ID_EX_MemRead_i != NOAC) && (ID_EX_Rt_i != 5'd0) &&
                      ((uses_rs(IF_ID_Op_i) && (IF_ID_Rs_i == ID_EX_Rt_i)) ||
                       (uses_rt(IF_ID_Op_i) && (IF_ID_Rt_i == ID_EX_Rt_i)));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        timeout_d     = timeout_q;
        Stall_o       = 1'b0;
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_Flush_o    = 1'b0;
        Pipe_Freeze_o = 1'b0;

        if (!rst_i) begin
            state_d   = ST_RUN;
            wait_d    = '0;
            timeout_d = 1'b0;
        end else if (Dmem_busy_i) begin
            Pipe_Freeze_o = 1'b1;
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            state_d       = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                wait_d = WAIT_W'(1);
            end else if (wait_q == WAIT_MAX) begin
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end else begin
            state_d = ST_RUN;
            wait_d  = '0;
            if (load_use) begin
                // A redirect seen here is dropped; ID re-presents it next cycle.
                Stall_o       = 1'b1;
                PCWrite_o     = 1'b0;
                IF_ID_Write_o = 1'b0;
            end else begin
                IF_Flush_o = Branch_taken_i | Jump_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout_o = timeout_q;

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (Stall_o | Pipe_Freeze_o),
        .count_o (StallCnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a queue-based scoreboard of expected outputs.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [4:0]  rs, rt, ex_rt;
    logic [1:0]  mem_rd;
    logic        br, jmp, busy;
    logic        stall, pcw, ifw, flush, frz, tmo;
    logic [31:0] cnt;

    typedef struct packed {
        logic        stall;
        logic        pcw;
        logic        ifw;
        logic        flush;
        logic        frz;
        logic [31:0] cnt;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    string       tag_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt     = 32'd0;
    logic        exp_tmo     = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .IF_ID_Op_i      (op),
        .IF_ID_Rs_i      (rs),
        .IF_ID_Rt_i      (rt),
        .ID_EX_MemRead_i (mem_rd),
        .ID_EX_Rt_i      (ex_rt),
        .Branch_taken_i  (br),
        .Jump_i          (jmp),
        .Dmem_busy_i     (busy),
        .Stall_o         (stall),
        .PCWrite_o       (pcw),
        .IF_ID_Write_o   (ifw),
        .IF_Flush_o      (flush),
        .Pipe_Freeze_o   (frz),
        .StallCnt_o      (cnt),
        .Timeout_o       (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare mid-cycle.
    task automatic step(input logic [5:0] i_op, input logic [4:0] i_rs, input logic [4:0] i_rt,
                        input logic [1:0] i_mr, input logic [4:0] i_ert, input logic i_br,
                        input logic i_j, input logic i_busy, input logic i_rst,
                        input logic es, input logic ep, input logic ei, input logic ef,
                        input logic ez, input string tag);
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        op = i_op; rs = i_rs; rt = i_rt; mem_rd = i_mr; ex_rt = i_ert;
        br = i_br; jmp = i_j; busy = i_busy; rst = i_rst;
        e = '{stall: es, pcw: ep, ifw: ei, flush: ef, frz: ez, cnt: exp_cnt, tmo: exp_tmo};
        sb.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = sb.pop_front();
        t = tag_q.pop_front();
        chk({t, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
        chk({t, ".pcwrite"}, {31'd0, pcw}, {31'd0, e.pcw});
        chk({t, ".ifid_write"}, {31'd0, ifw}, {31'd0, e.ifw});
        chk({t, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
        chk({t, ".freeze"}, {31'd0, frz}, {31'd0, e.frz});
        chk({t, ".stallcnt"}, cnt, e.cnt);
        chk({t, ".timeout"}, {31'd0, tmo}, {31'd0, e.tmo});
        if (!i_rst) begin
            exp_cnt = 32'd0;
            exp_tmo = 1'b0;
        end else if ((es | ez) && (exp_cnt != 32'hFFFF_FFFF)) begin
            exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    task automatic idle(input string tag);
        step(OP_RTYPE, 5'd1, 5'd4, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, tag);
    endtask

    task automatic mem_busy(input string tag);
        step(OP_RTYPE, 5'd1, 5'd4, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; op = OP_RTYPE; rs = 5'd0; rt = 5'd0; mem_rd = 2'd0; ex_rt = 5'd0;
        br = 1'b0; jmp = 1'b0; busy = 1'b0;

        // Reset cycle forces run-enables even with busy, load-use and redirect present.
        step(OP_RTYPE, 5'd2, 5'd4, 2'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset_outs");
        idle("idle0");

        // Load-use: lw $2 in EX, add $3,$2,$4 in ID.
        step(OP_RTYPE, 5'd2, 5'd4, 2'd3, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lu_add");
        idle("lu_release");
        // rt of addi is a destination, not a source.
        step(OP_ADDI, 5'd5, 5'd2, 2'd3, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "addi_rt_dest");
        step(OP_RTYPE, 5'd0, 5'd0, 2'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "lw_r0");
        // Jump does not read rs, so a matching rs field is not a hazard.
        step(OP_JUMP, 5'd2, 5'd0, 2'd3, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "jump_no_rs");
        step(OP_SW, 5'd1, 5'd2, 2'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sw_rt_lu");
        step(OP_ADDI, 5'd7, 5'd9, 2'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "addi_rs_lu");

        // Redirects.
        step(OP_BRANCH, 5'd1, 5'd3, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "br_flush");
        step(OP_BRANCH, 5'd1, 5'd2, 2'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "br_with_lu");
        step(OP_BRANCH, 5'd1, 5'd2, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "br_retry");

        // Three-cycle memory wait; freeze outranks load-use and redirect.
        mem_busy("mw1");
        step(OP_RTYPE, 5'd2, 5'd4, 2'd3, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mw2_prio");
        mem_busy("mw3");
        // Exit from the wait evaluates run-mode outputs in the same cycle.
        step(OP_RTYPE, 5'd2, 5'd4, 2'd3, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mw_exit_lu");
        idle("mw_after");

        // Seventeen busy cycles trip the sticky timeout on the last edge.
        for (int i = 0; i < 17; i++) mem_busy("tmo_busy");
        exp_tmo = 1'b1;
        idle("tmo_sticky0");
        idle("tmo_sticky1");

        // Reset in the middle of a memory wait.
        mem_busy("rmw1");
        mem_busy("rmw2");
        step(OP_RTYPE, 5'd1, 5'd4, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rmw_reset");
        idle("rmw_after");
        mem_busy("post_rst_busy");
        idle("post_rst_idle");
        step(OP_RTYPE, 5'd3, 5'd6, 2'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rt_jump_drop");
        idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
